rc_event_logger: RTL and testbench
==================================

Name: rc_event_logger

Overview:
- Single-clock logger that watches MMCM reconfiguration requests (RCEN) and the MMCM's ready/acknowledge (RCRDY).
- Each request produces a 2-word timestamped record: outcome, sequence number and duration.
- Records go into an internal FWFT FIFO that feeds the control_interface DATA_FIFO port, so the PC reads reconfiguration history over TCP.
- Runs on clk_control_interface.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of 2, >= 4.
- TIMEOUT, 1000000, maximum cycles allowed per wait state before the attempt is abandoned.

Ports:
- CLK  in  1  control-interface clock
- RESET_N  in  1  asynchronous, active-low reset
- RCEN  in  1  single-cycle reconfiguration request, same pulse as driven to mmcm
- RCRDY  in  1  mmcm ready; asynchronous to CLK
- CLR  in  1  synchronous flush/clear pulse (from PULSE_REG)
- DATA_FIFO_Q  out  32  FWFT head word
- DATA_FIFO_EMPTY  out  1  FIFO empty
- DATA_FIFO_RDREQ  in  1  pop head word
- BUSY  out  1  high while an attempt is being tracked
- EVENT_CNT  out  16  records written, saturating
- DROP_CNT  out  16  requests not logged, saturating

Behaviour:
- Reset (RESET_N low, async): FSM=IDLE, DATA_FIFO_Q=0, DATA_FIFO_EMPTY=1, BUSY=0, counters/seq/timestamp=0, FIFO pointers=0.
- RCRDY passes through a 2-flop synchronizer to give rcrdy_s; all decisions use rcrdy_s.
- ts: 32-bit free-running cycle counter, wraps 0xFFFFFFFF->0.
- dur: 32-bit counter, cleared on RCEN acceptance, +1 per cycle in WAIT_LOW/WAIT_HIGH, saturates at 0xFFFFFFFF.
- wt: per-state wait counter, cleared on each state entry.
- FSM states: IDLE, WAIT_LOW, WAIT_HIGH, PUSH0, PUSH1.
  - IDLE, RCEN=1, rcrdy_s=1: latch start_ts=ts, clear dur, go WAIT_LOW, BUSY=1 from next cycle.
  - IDLE, RCEN=1, rcrdy_s=0: status=3 (rejected), dur=0, go PUSH0.
  - WAIT_LOW: rcrdy_s=0 -> WAIT_HIGH; wt reaching TIMEOUT -> status=1, go PUSH0.
  - WAIT_HIGH: rcrdy_s=1 -> status=0, go PUSH0; wt reaching TIMEOUT -> status=2, go PUSH0.
  - PUSH0: if free words >= 2, write word0 and go PUSH1; otherwise DROP_CNT+1 and go IDLE, seq unchanged.
  - PUSH1: write word1, EVENT_CNT+1, seq+1 (8-bit, wraps), go IDLE.
- Record is atomic: both words or neither.
  - word0 = {4'hA, status[1:0], 2'b00, seq[7:0], start_ts[15:0]}.
  - word1 = dur, i.e. cycles from the RCEN-accept cycle to the cycle the exit condition is seen.
- RCEN while not IDLE (including PUSH0/PUSH1): ignored, DROP_CNT+1.
- BUSY = (FSM != IDLE).
- FIFO behaviour (FWFT):
  - DATA_FIFO_Q always shows the head word when DATA_FIFO_EMPTY=0.
  - A word written at edge n is visible, with EMPTY low, after edge n.
  - DATA_FIFO_RDREQ while EMPTY=1: ignored.
  - Simultaneous read and write: count unchanged, pointers both advance.
  - Free-space check uses the count at PUSH0, so a concurrent read never causes a drop it would have avoided, nor an overflow.
- CLR (synchronous, highest priority over all other events in that cycle): FSM->IDLE, FIFO flushed (EMPTY=1 next cycle), ts/seq/EVENT_CNT/DROP_CNT=0. An in-flight attempt is discarded without a record.
- RESET_N asserted mid-record: the partial record is lost; FIFO empty after release.

Test Plan:
- Normal request: RESET_N release; idle with RCRDY=1; RCEN at ts=100; raw RCRDY low at +5, high at +40 -> word0=0xA0000064, word1=42 (includes 2-cycle sync delay); EVENT_CNT=1; BUSY high for the attempt.
- Rejected: RCRDY held low, RCEN pulse -> one record with status=3, word1=0; seq advances to 1.
- Timeouts: TIMEOUT=64.
  - RCRDY never drops -> status=1.
  - Second run: RCRDY drops but never returns -> status=2, word1=64+64 region (exact value checked against the model).
  - BUSY falls after PUSH1.
- FIFO full: DEPTH=4, two accepted records with no reads -> third request gives DROP_CNT=1, FIFO holds 4 words; pop one word then request again -> still dropped (free=1); pop all -> next request logged.
- Overlap/CLR: RCEN during WAIT_HIGH -> DROP_CNT+1, tracking continues. CLR during WAIT_HIGH -> IDLE, EMPTY=1, counters 0, no record.
- Async reset mid-PUSH1: assert RESET_N low between words -> outputs at reset values immediately; after release EMPTY=1, seq=0.

Source files
------------

// File: rtl/rc_event_logger.sv
// MMCM reconfiguration event logger: times each request/ready handshake and queues a
// two-word record per attempt into a first-word-fall-through FIFO for the control interface.
module rc_event_logger #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        RCEN,
    input  logic        RCRDY,
    input  logic        CLR,
    output logic [31:0] DATA_FIFO_Q,
    output logic        DATA_FIFO_EMPTY,
    input  logic        DATA_FIFO_RDREQ,
    output logic        BUSY,
    output logic [15:0] EVENT_CNT,
    output logic [15:0] DROP_CNT
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {StIdle, StWaitLow, StWaitHigh, StPush0, StPush1} state_e;

    state_e      state_q, state_d;
    logic        rcrdy_meta_q, rcrdy_s_q;
    // Only the low half of the timestamp is ever recorded, so only that half is kept.
    logic [15:0] ts_q;
    logic [15:0] start_ts_q, start_ts_d;
    logic [31:0] dur_q, dur_d;
    logic [31:0] wt_q, wt_d;
    logic [1:0]  status_q, status_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] event_cnt_q, event_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        drop_full, drop_busy;
    logic [16:0] drop_sum;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, free_ok, timeout;
    logic [31:0]   push_data;

    assign pop     = DATA_FIFO_RDREQ && (count_q != '0);
    assign free_ok = (32'(count_q) + 32'd2) <= DEPTH;
    assign timeout = (wt_q == TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        start_ts_d  = start_ts_q;
        dur_d       = dur_q;
        wt_d        = wt_q;
        status_d    = status_q;
        seq_d       = seq_q;
        event_cnt_d = event_cnt_q;
        push        = 1'b0;
        push_data   = '0;
        drop_full   = 1'b0;
        drop_busy   = RCEN && (state_q != StIdle);

        if (state_q inside {StWaitLow, StWaitHigh}) begin
            dur_d = (dur_q == '1) ? dur_q : dur_q + 32'd1;
            wt_d  = wt_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (RCEN) begin
                    start_ts_d = ts_q;
                    dur_d      = '0;
                    wt_d       = '0;
                    if (rcrdy_s_q) begin
                        state_d = StWaitLow;
                    end else begin
                        status_d = 2'd3;
                        state_d  = StPush0;
                    end
                end
            end
            StWaitLow: begin
                if (!rcrdy_s_q) begin
                    wt_d    = '0;
                    state_d = StWaitHigh;
                end else if (timeout) begin
                    status_d = 2'd1;
                    state_d  = StPush0;
                end
            end
            StWaitHigh: begin
                if (rcrdy_s_q) begin
                    status_d = 2'd0;
                    state_d  = StPush0;
                end else if (timeout) begin
                    status_d = 2'd2;
                    state_d  = StPush0;
                end
            end
            StPush0: begin
                // Both words must fit now; a record is never split across a full FIFO.
                if (free_ok) begin
                    push      = 1'b1;
                    push_data = {4'hA, status_q, 2'b00, seq_q, start_ts_q};
                    state_d   = StPush1;
                end else begin
                    drop_full = 1'b1;
                    state_d   = StIdle;
                end
            end
            StPush1: begin
                push        = 1'b1;
                push_data   = dur_q;
                event_cnt_d = (event_cnt_q == '1) ? event_cnt_q : event_cnt_q + 16'd1;
                seq_d       = seq_q + 8'd1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_full) + 17'(drop_busy);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rcrdy_meta_q <= 1'b0;
            rcrdy_s_q    <= 1'b0;
        end else begin
            rcrdy_meta_q <= RCRDY;
            rcrdy_s_q    <= rcrdy_meta_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            ts_q        <= '0;
            start_ts_q  <= '0;
            dur_q       <= '0;
            wt_q        <= '0;
            status_q    <= '0;
            seq_q       <= '0;
            event_cnt_q <= '0;
            drop_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else if (CLR) begin
            state_q     <= StIdle;
            ts_q        <= '0;
            dur_q       <= '0;
            wt_q        <= '0;
            seq_q       <= '0;
            event_cnt_q <= '0;
            drop_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_q + 16'd1;
            start_ts_q  <= start_ts_d;
            dur_q       <= dur_d;
            wt_q        <= wt_d;
            status_q    <= status_d;
            seq_q       <= seq_d;
            event_cnt_q <= event_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !CLR) mem[wr_ptr_q] <= push_data;
    end

    assign DATA_FIFO_EMPTY = (count_q == '0);
    assign DATA_FIFO_Q     = DATA_FIFO_EMPTY ? 32'd0 : mem[rd_ptr_q];
    assign BUSY            = (state_q != StIdle);
    assign EVENT_CNT       = event_cnt_q;
    assign DROP_CNT        = drop_cnt_q;

endmodule

// File: tb/tb_rc_event_logger.sv
// Directed bench for rc_event_logger (DEPTH=4, TIMEOUT=64): normal, rejected, timeout,
// FIFO-full, overlap/clear and async-reset scenarios with hand-computed records.
module tb_rc_event_logger;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        rcen  = 1'b0;
    logic        rcrdy = 1'b1;
    logic        clr   = 1'b0;
    logic        rdreq = 1'b0;
    logic [31:0] q;
    logic        empty;
    logic        busy;
    logic [15:0] ev;
    logic [15:0] dr;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_ts;
    logic [31:0] w0;
    logic [31:0] w0b;

    rc_event_logger #(
        .DEPTH  (4),
        .TIMEOUT(64)
    ) dut (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .RCEN           (rcen),
        .RCRDY          (rcrdy),
        .CLR            (clr),
        .DATA_FIFO_Q    (q),
        .DATA_FIFO_EMPTY(empty),
        .DATA_FIFO_RDREQ(rdreq),
        .BUSY           (busy),
        .EVENT_CNT      (ev),
        .DROP_CNT       (dr)
    );

    always #5 clk = ~clk;

    // Reference cycle counter for the start timestamp field.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)   m_ts <= 32'd0;
        else if (clr) m_ts <= 32'd0;
        else          m_ts <= m_ts + 32'd1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk(tag, q, exp);
        rdreq = 1'b1;
        step(1);
        rdreq = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_q", q, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ev", 32'(ev), 32'd0);
        chk("rst_dr", 32'(dr), 32'd0);
        #19 rst_n = 1'b1;

        // Normal request at ts=100; RCRDY low at +5, high at +40.
        step(100);
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        chk("norm_busy1", 32'(busy), 32'd1);
        step(4);
        rcrdy = 1'b0;
        step(35);
        rcrdy = 1'b1;
        chk("norm_busy40", 32'(busy), 32'd1);
        step(4);
        chk("norm_empty44", 32'(empty), 32'd0);
        chk("norm_busy44", 32'(busy), 32'd1);
        step(1);
        chk("norm_busy45", 32'(busy), 32'd0);
        chk("norm_ev", 32'(ev), 32'd1);
        pop_chk("norm_w0", 32'hA000_0064);
        pop_chk("norm_w1", 32'd42);
        chk("norm_drained", 32'(empty), 32'd1);

        // Rejected: RCRDY low when the request arrives.
        rcrdy = 1'b0;
        step(3);
        w0 = {8'hAC, 8'd1, m_ts[15:0]};
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        step(1);
        chk("rej_empty", 32'(empty), 32'd0);
        step(1);
        chk("rej_ev", 32'(ev), 32'd2);
        chk("rej_busy", 32'(busy), 32'd0);
        pop_chk("rej_w0", w0);
        pop_chk("rej_w1", 32'd0);

        // Timeout in WAIT_LOW: RCRDY never drops.
        rcrdy = 1'b1;
        step(3);
        w0 = {8'hA4, 8'd2, m_ts[15:0]};
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        step(64);
        chk("to1_busy65", 32'(busy), 32'd1);
        chk("to1_empty65", 32'(empty), 32'd1);
        step(1);
        chk("to1_busy66", 32'(busy), 32'd1);
        chk("to1_empty66", 32'(empty), 32'd0);
        step(1);
        chk("to1_busy67", 32'(busy), 32'd0);
        pop_chk("to1_w0", w0);
        pop_chk("to1_w1", 32'd64);

        // Timeout in WAIT_HIGH: RCRDY drops with the request and never returns.
        w0 = {8'hA8, 8'd3, m_ts[15:0]};
        rcen  = 1'b1;
        rcrdy = 1'b0;
        step(1);
        rcen = 1'b0;
        step(66);
        chk("to2_empty67", 32'(empty), 32'd1);
        step(1);
        chk("to2_empty68", 32'(empty), 32'd0);
        step(1);
        chk("to2_busy69", 32'(busy), 32'd0);
        chk("to2_ev", 32'(ev), 32'd4);
        pop_chk("to2_w0", w0);
        pop_chk("to2_w1", 32'd66);

        // FIFO full with DEPTH=4: two rejected records fill it.
        step(3);
        w0 = {8'hAC, 8'd4, m_ts[15:0]};
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        step(2);
        w0b = {8'hAC, 8'd5, m_ts[15:0]};
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        step(2);
        chk("full_ev", 32'(ev), 32'd6);
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        step(1);
        chk("full_dr1", 32'(dr), 32'd1);
        chk("full_ev_kept", 32'(ev), 32'd6);
        pop_chk("full_a_w0", w0);
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        step(1);
        chk("full_dr2", 32'(dr), 32'd2);
        pop_chk("full_a_w1", 32'd0);
        pop_chk("full_b_w0", w0b);
        pop_chk("full_b_w1", 32'd0);
        chk("full_drained", 32'(empty), 32'd1);
        rdreq = 1'b1;
        step(1);
        rdreq = 1'b0;
        chk("empty_rd_ignored", 32'(empty), 32'd1);
        w0 = {8'hAC, 8'd6, m_ts[15:0]};
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        step(1);
        chk("after_full_w0", q, w0);
        step(1);
        chk("after_full_ev", 32'(ev), 32'd7);

        // Overlapping request during WAIT_HIGH, then CLR discards the attempt.
        rcrdy = 1'b1;
        step(3);
        rcen  = 1'b1;
        rcrdy = 1'b0;
        step(1);
        rcen = 1'b0;
        step(4);
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        chk("ovl_dr", 32'(dr), 32'd3);
        chk("ovl_busy", 32'(busy), 32'd1);
        step(2);
        chk("ovl_busy8", 32'(busy), 32'd1);
        chk("ovl_q_old", q, w0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_ev", 32'(ev), 32'd0);
        chk("clr_dr", 32'(dr), 32'd0);
        chk("clr_q", q, 32'd0);
        rcrdy = 1'b1;
        step(80);
        chk("clr_no_record", 32'(empty), 32'd1);
        chk("clr_idle", 32'(busy), 32'd0);

        // Sequence number and timestamp restart after CLR.
        rcrdy = 1'b0;
        step(3);
        w0 = {8'hAC, 8'd0, m_ts[15:0]};
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        step(2);
        chk("postclr_ev", 32'(ev), 32'd1);
        pop_chk("postclr_w0", w0);
        pop_chk("postclr_w1", 32'd0);

        // Async reset between the two words of a record.
        w0 = {8'hAC, 8'd1, m_ts[15:0]};
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        step(1);
        chk("mid_q", q, w0);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_q", q, 32'd0);
        chk("arst_ev", 32'(ev), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("rel_empty", 32'(empty), 32'd1);
        w0 = {8'hAC, 8'd0, m_ts[15:0]};
        rcen = 1'b1;
        step(1);
        rcen = 1'b0;
        step(1);
        chk("rel_w0", q, w0);
        step(1);
        chk("rel_ev", 32'(ev), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
